br_resolve_ctrl: RTL and testbench
==================================

# br_resolve_ctrl

Sequencing controller for branch resolution in the decode stage of the MIPS pipeline. It accepts one branch at a time from decode and waits for operand readiness. It resolves the branch through the `brcal` comparator, then holds the outcome until the delay-slot instruction issues. For a taken branch it then presents a redirect to fetch over a valid/ready handshake. It also drives the decode stall, honours commit-stage flushes, and keeps a taken-branch counter.

## Interface
- `PC_W`, 32, width of PC and target
- `CNT_W`, 16, width of the taken-branch counter
- `clk` in 1: clock. Everything is rising-edge.
- `rst` in 1: reset. Asynchronous and active-high.
- `br_valid` in 1: decode presents a branch.
- `br_ready` out 1: controller can accept a branch. Combinational: `state==IDLE && !flush`.
- `br_type` in 7: one-hot compare select. Bits: 0 E, 1 NE, 2 GE, 3 GT, 4 LE, 5 LT, 6 J.
- `br_target` in `PC_W`: precomputed branch target.
- `rs_ok`, `rt_ok` in 1 each: forwarded operand is valid this cycle.
- `rd1`, `rd2` in 32: operand values.
- `slot_issue` in 1: delay-slot instruction leaves decode this cycle.
- `flush` in 1: exception/ERET flush from commit.
- `stall_id` out 1: hold the decode stage.
- `redir_valid` out 1: redirect request to fetch.
- `redir_pc` out `PC_W`: redirect address.
- `redir_ready` in 1: fetch accepts the redirect.
- `busy` out 1: `state!=IDLE`.
- `taken_cnt` out `CNT_W`: number of taken branches whose redirect completed. Wraps.

## Operation
- States and transitions:
  - IDLE → RESOLVE on `br_valid && br_ready`.
  - RESOLVE → WAIT_SLOT when `rs_ok && rt_ok`.
  - WAIT_SLOT → REDIR on `slot_issue` if taken.
  - WAIT_SLOT → IDLE on `slot_issue` if not taken.
  - REDIR → IDLE on `redir_ready`.
- Acceptance captures `br_type` and `br_target` into registers.
- RESOLVE:
  - Drives the captured `br_type` and live `rd1`/`rd2` into `brcal`.
  - In the cycle where both operands are ok, latches `taken = brcal_out` and `tgt = br_target`.
- `brcal` semantics, all signed 32-bit:
  - E: `rd1==rd2`. NE: `rd1!=rd2`.
  - GE: `rd1>=0`. GT: `rd1>0`. LE: `rd1<=0`. LT: `rd1<0`.
  - J: always taken.
  - Several bits set: lowest index wins. All zero: not taken.
- `stall_id` = `state==RESOLVE && !(rs_ok && rt_ok)`. It is 0 in every other state.
- `slot_issue` is ignored outside WAIT_SLOT.
- REDIR:
  - `redir_valid`=1 and `redir_pc`=`tgt`, both held stable until `redir_ready`.
  - `taken_cnt` increments by 1 in the handshake cycle and wraps at 2^`CNT_W`.
- `flush` has priority over everything:
  - In any state, the next state is IDLE.
  - Captured data is discarded and no redirect is issued.
  - `taken_cnt` is unchanged, even if `redir_ready` is high in the same cycle.
- Reset: state IDLE, `taken`=0, `tgt`=0, `taken_cnt`=0.
- Output values during reset:
  - `redir_valid`=0, `redir_pc`=0, `stall_id`=0, `busy`=0.
  - `br_ready`=1 unless `flush` is high.
- Reset mid-operation aborts immediately, asynchronously.

## Timing
- Branch accepted at T → RESOLVE at T+1.
- Operands ready at T+1 → WAIT_SLOT at T+2.
- Earliest `slot_issue` at T+2 → `redir_valid` at T+3 (taken) or IDLE at T+3 (not taken).
- Every stalled RESOLVE cycle adds 1 cycle. Every `redir_ready`=0 cycle in REDIR adds 1 cycle.
- Back-to-back branches:
  - Next accept is possible in the cycle the FSM is in IDLE.
  - Minimum spacing is 3 cycles (not taken) or 4 cycles (taken, immediate `redir_ready`).
- `redir_valid` is never retracted before `redir_ready`, except by `flush` or `rst`.

## Structure
- Shared package `br_pkg` holds:
  - State enum `{IDLE, RESOLVE, WAIT_SLOT, REDIR}`.
  - Bit-index constants `BR_E`..`BR_J` (0..6) for `br_type`.
- Sub-module: one `brcal` instance, fully combinational, fed from captured and live signals.
- The controller owns all state.

## Test plan
- BEQ, `br_type`=7'b0000001, `rd1`=`rd2`=0x5, ops ok at T+1, `slot_issue` at T+2, `redir_ready`=1 → `redir_valid` at T+3 with `redir_pc`=`br_target`=0xBFC0_0100; `taken_cnt` 0→1.
- BGTZ, `rd1`=0x8000_0000 → not taken; no `redir_valid`; IDLE at T+3; `taken_cnt` unchanged.
- BNE with `rs_ok`=0 for 3 cycles → `stall_id`=1 for exactly those 3 cycles; then resolves taken; redirect 3 cycles later than the baseline.
- Taken J with `redir_ready`=0 for 2 cycles → `redir_valid`/`redir_pc` held stable for 3 cycles; counter increments once.
- `flush` asserted in WAIT_SLOT with a taken branch pending → IDLE next cycle; no `redir_valid` ever; `br_ready`=0 during the `flush` cycle.
- `rst` pulsed during REDIR → `redir_valid` drops asynchronously; `taken_cnt`=0; next branch is accepted normally after release.

Source files
------------

// File: rtl/br_pkg.sv
// Shared types for the decode-stage branch resolution controller:
// FSM state encoding and br_type one-hot bit positions.
package br_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RESOLVE   = 2'd1,
    WAIT_SLOT = 2'd2,
    REDIR     = 2'd3
  } br_state_e;

  localparam int BR_E  = 0;
  localparam int BR_NE = 1;
  localparam int BR_GE = 2;
  localparam int BR_GT = 3;
  localparam int BR_LE = 4;
  localparam int BR_LT = 5;
  localparam int BR_J  = 6;

endpackage

// File: rtl/brcal.sv
// Combinational branch comparator: signed 32-bit compares selected by a
// one-hot br_type; the lowest set bit wins, all-zero means not taken.
module brcal
  import br_pkg::*;
(
  input  logic [6:0]  br_type,
  input  logic [31:0] rd1,
  input  logic [31:0] rd2,
  output logic        taken
);

  logic rd1_neg;
  logic rd1_zero;

  assign rd1_neg  = rd1[31];
  assign rd1_zero = (rd1 == 32'd0);

  always_comb begin
    taken = 1'b0;
    if      (br_type[BR_E])  taken = (rd1 == rd2);
    else if (br_type[BR_NE]) taken = (rd1 != rd2);
    else if (br_type[BR_GE]) taken = !rd1_neg;
    else if (br_type[BR_GT]) taken = !rd1_neg && !rd1_zero;
    else if (br_type[BR_LE]) taken = rd1_neg || rd1_zero;
    else if (br_type[BR_LT]) taken = rd1_neg;
    else if (br_type[BR_J])  taken = 1'b1;
  end

endmodule

// File: rtl/br_resolve_ctrl.sv
// Branch resolution sequencer: accept, resolve via brcal, wait for the delay
// slot, then redirect fetch for taken branches. Flush and rst abort any state.
module br_resolve_ctrl
  import br_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [6:0]       br_type,
  input  logic [PC_W-1:0]  br_target,
  input  logic             rs_ok,
  input  logic             rt_ok,
  input  logic [31:0]      rd1,
  input  logic [31:0]      rd2,
  input  logic             slot_issue,
  input  logic             flush,
  output logic             stall_id,
  output logic             redir_valid,
  output logic [PC_W-1:0]  redir_pc,
  input  logic             redir_ready,
  output logic             busy,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [1:0]       state_dbg
);

  // Handshakes: a transfer occurs in a cycle where valid && ready are both
  // high at the rising edge; valid, once raised, holds with its payload
  // until that cycle (only flush or rst may withdraw it).

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  br_state_e        state_q, state_d;
  logic [6:0]       type_q, type_d;
  logic [PC_W-1:0]  btgt_q, btgt_d;
  logic             taken_q, taken_d;
  logic [PC_W-1:0]  tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ops_ok;
  logic             cmp_taken;

  brcal u_brcal (
    .br_type (type_q),
    .rd1     (rd1),
    .rd2     (rd2),
    .taken   (cmp_taken)
  );

  assign ops_ok      = rs_ok && rt_ok;
  assign br_ready    = (state_q == IDLE) && !flush;
  assign stall_id    = (state_q == RESOLVE) && !ops_ok;
  assign busy        = (state_q != IDLE);
  assign redir_valid = (state_q == REDIR);
  assign redir_pc    = (state_q == REDIR) ? tgt_q : '0;
  assign taken_cnt   = cnt_q;
  assign state_dbg   = state_q;

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    btgt_d  = btgt_q;
    taken_d = taken_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    if (flush) begin
      // Discard the in-flight branch; the counter is left untouched.
      state_d = IDLE;
      taken_d = 1'b0;
      tgt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (br_valid) begin
            state_d = RESOLVE;
            type_d  = br_type;
            btgt_d  = br_target;
          end
        end
        RESOLVE: begin
          if (ops_ok) begin
            state_d = WAIT_SLOT;
            taken_d = cmp_taken;
            tgt_d   = btgt_q;
          end
        end
        WAIT_SLOT: begin
          if (slot_issue) state_d = taken_q ? REDIR : IDLE;
        end
        REDIR: begin
          if (redir_ready) begin
            state_d = IDLE;
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      type_q  <= '0;
      btgt_q  <= '0;
      taken_q <= 1'b0;
      tgt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      btgt_q  <= btgt_d;
      taken_q <= taken_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_br_resolve_ctrl.sv
// Directed bench for br_resolve_ctrl: each step drives one cycle of inputs
// and checks outputs against hand-computed values.
module tb_br_resolve_ctrl;
  import br_pkg::*;

  localparam int PC_W  = 32;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             br_valid;
  logic             br_ready;
  logic [6:0]       br_type;
  logic [PC_W-1:0]  br_target;
  logic             rs_ok;
  logic             rt_ok;
  logic [31:0]      rd1;
  logic [31:0]      rd2;
  logic             slot_issue;
  logic             flush;
  logic             stall_id;
  logic             redir_valid;
  logic [PC_W-1:0]  redir_pc;
  logic             redir_ready;
  logic             busy;
  logic [CNT_W-1:0] taken_cnt;
  logic [1:0]       state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  logic [CNT_W-1:0] exp_cnt;

  br_resolve_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .br_valid    (br_valid),
    .br_ready    (br_ready),
    .br_type     (br_type),
    .br_target   (br_target),
    .rs_ok       (rs_ok),
    .rt_ok       (rt_ok),
    .rd1         (rd1),
    .rd2         (rd2),
    .slot_issue  (slot_issue),
    .flush       (flush),
    .stall_id    (stall_id),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .redir_ready (redir_ready),
    .busy        (busy),
    .taken_cnt   (taken_cnt),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    br_valid    = 1'b0;
    rs_ok       = 1'b1;
    rt_ok       = 1'b1;
    slot_issue  = 1'b0;
    flush       = 1'b0;
    redir_ready = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One branch with operands ready at once, slot at T+2, immediate redir_ready.
  task automatic run_branch(input string tag, input logic [6:0] typ, input logic [31:0] tgt,
                            input logic [31:0] a, input logic [31:0] b, input logic exp_taken);
    cyc(); idle_inputs();
    br_valid = 1'b1; br_type = typ; br_target = tgt;
    settle();
    chk({tag, ":accept_ready"}, 32'(br_ready), 32'd1);
    cyc(); idle_inputs();
    rd1 = a; rd2 = b;
    settle();
    chk({tag, ":resolve_state"}, 32'(state_dbg), 32'(RESOLVE));
    chk({tag, ":resolve_stall"}, 32'(stall_id), 32'd0);
    cyc(); idle_inputs();
    slot_issue = 1'b1;
    settle();
    chk({tag, ":wait_state"}, 32'(state_dbg), 32'(WAIT_SLOT));
    cyc(); idle_inputs();
    redir_ready = 1'b1;
    settle();
    chk({tag, ":redir_valid"}, 32'(redir_valid), 32'(exp_taken));
    if (exp_taken) begin
      chk({tag, ":redir_pc"}, redir_pc, tgt);
      exp_cnt = exp_cnt + 1'b1;
    end else begin
      chk({tag, ":idle_state"}, 32'(state_dbg), 32'(IDLE));
    end
    cyc(); idle_inputs();
    settle();
    chk({tag, ":after_state"}, 32'(state_dbg), 32'(IDLE));
    chk({tag, ":after_cnt"}, 32'(taken_cnt), 32'(exp_cnt));
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    br_type = 7'd0; br_target = '0; rd1 = '0; rd2 = '0;
    exp_cnt = '0;
    #3;
    chk("rst_redir_valid", 32'(redir_valid), 32'd0);
    chk("rst_redir_pc", redir_pc, 32'd0);
    chk("rst_stall", 32'(stall_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_br_ready", 32'(br_ready), 32'd1);
    chk("rst_cnt", 32'(taken_cnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // BEQ taken, BGTZ with negative rd1 not taken
    run_branch("beq", 7'b0000001, 32'hBFC0_0100, 32'h5, 32'h5, 1'b1);
    run_branch("bgtz", 7'b0001000, 32'h0000_1000, 32'h8000_0000, 32'h0, 1'b0);
    // GE on zero taken, LT on positive not taken, LE on negative taken
    run_branch("bgez0", 7'b0000100, 32'h0000_2000, 32'h0, 32'h0, 1'b1);
    run_branch("bltz_pos", 7'b0100000, 32'h0000_3000, 32'h7FFF_FFFF, 32'h0, 1'b0);
    run_branch("blez_neg", 7'b0010000, 32'h0000_4000, 32'hFFFF_FFFF, 32'h0, 1'b1);
    // NE beats J when both set; all-zero type is never taken
    run_branch("ne_over_j", 7'b1000010, 32'h0000_5000, 32'h7, 32'h7, 1'b0);
    run_branch("none", 7'b0000000, 32'h0000_6000, 32'h1, 32'h2, 1'b0);

    // BNE with rs_ok low for 3 cycles
    cyc(); idle_inputs();
    br_valid = 1'b1; br_type = 7'b0000010; br_target = 32'h0000_0AA0;
    settle();
    chk("bne_accept", 32'(br_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(); idle_inputs();
      rs_ok = 1'b0; rd1 = 32'h1; rd2 = 32'h2;
      settle();
      chk($sformatf("bne_stall%0d", i), 32'(stall_id), 32'd1);
    end
    cyc(); idle_inputs();
    settle();
    chk("bne_stall_clear", 32'(stall_id), 32'd0);
    cyc(); idle_inputs();
    slot_issue = 1'b1;
    settle();
    chk("bne_wait", 32'(state_dbg), 32'(WAIT_SLOT));
    chk("bne_wait_stall", 32'(stall_id), 32'd0);
    cyc(); idle_inputs();
    redir_ready = 1'b1;
    settle();
    chk("bne_redir_valid", 32'(redir_valid), 32'd1);
    chk("bne_redir_pc", redir_pc, 32'h0000_0AA0);
    exp_cnt = exp_cnt + 1'b1;
    cyc(); idle_inputs();
    settle();
    chk("bne_cnt", 32'(taken_cnt), 32'(exp_cnt));

    // J with redir_ready low for 2 cycles
    cyc(); idle_inputs();
    br_valid = 1'b1; br_type = 7'b1000000; br_target = 32'h0040_0020;
    cyc(); idle_inputs();
    cyc(); idle_inputs();
    slot_issue = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(); idle_inputs();
      redir_ready = (i == 2);
      settle();
      chk($sformatf("j_hold_valid%0d", i), 32'(redir_valid), 32'd1);
      chk($sformatf("j_hold_pc%0d", i), redir_pc, 32'h0040_0020);
      chk($sformatf("j_hold_cnt%0d", i), 32'(taken_cnt), 32'(exp_cnt));
    end
    exp_cnt = exp_cnt + 1'b1;
    cyc(); idle_inputs();
    settle();
    chk("j_cnt", 32'(taken_cnt), 32'(exp_cnt));
    chk("j_idle", 32'(state_dbg), 32'(IDLE));

    // flush in WAIT_SLOT with a taken BEQ pending
    cyc(); idle_inputs();
    br_valid = 1'b1; br_type = 7'b0000001; br_target = 32'h0000_7000;
    rd1 = 32'h9; rd2 = 32'h9;
    cyc(); idle_inputs();
    cyc(); idle_inputs();
    flush = 1'b1;
    settle();
    chk("fl_ws_br_ready", 32'(br_ready), 32'd0);
    cyc(); idle_inputs();
    slot_issue = 1'b1;
    settle();
    chk("fl_ws_idle", 32'(state_dbg), 32'(IDLE));
    chk("fl_ws_no_redir", 32'(redir_valid), 32'd0);
    cyc(); idle_inputs();
    settle();
    chk("fl_ws_no_redir2", 32'(redir_valid), 32'd0);
    chk("fl_ws_cnt", 32'(taken_cnt), 32'(exp_cnt));

    // flush in IDLE blocks acceptance
    cyc(); idle_inputs();
    br_valid = 1'b1; flush = 1'b1;
    settle();
    chk("fl_idle_br_ready", 32'(br_ready), 32'd0);
    cyc(); idle_inputs();
    settle();
    chk("fl_idle_stays", 32'(state_dbg), 32'(IDLE));

    // flush in REDIR with redir_ready high: counter unchanged
    cyc(); idle_inputs();
    br_valid = 1'b1; br_type = 7'b1000000; br_target = 32'h0000_8000;
    cyc(); idle_inputs();
    cyc(); idle_inputs();
    slot_issue = 1'b1;
    cyc(); idle_inputs();
    redir_ready = 1'b1; flush = 1'b1;
    settle();
    chk("fl_redir_valid", 32'(redir_valid), 32'd1);
    cyc(); idle_inputs();
    settle();
    chk("fl_redir_idle", 32'(state_dbg), 32'(IDLE));
    chk("fl_redir_cnt", 32'(taken_cnt), 32'(exp_cnt));

    // rst pulsed during REDIR
    cyc(); idle_inputs();
    br_valid = 1'b1; br_type = 7'b1000000; br_target = 32'h0000_9000;
    cyc(); idle_inputs();
    cyc(); idle_inputs();
    slot_issue = 1'b1;
    cyc(); idle_inputs();
    settle();
    chk("rst_mid_pre_valid", 32'(redir_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", 32'(redir_valid), 32'd0);
    chk("rst_mid_pc", redir_pc, 32'd0);
    chk("rst_mid_cnt", 32'(taken_cnt), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    exp_cnt = '0;
    @(negedge clk);
    rst = 1'b0;
    run_branch("post_rst", 7'b0000001, 32'h0000_A000, 32'h3, 32'h3, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
